// File: rtl/y_resp_compactor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : y_resp_compactor
// Purpose : Folds each accepted y word into a MISR signature and flags
//           pass/fail against an expected signature at the end of a run.
//           Optional X/Z sample check: define YRESP_XCHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module y_resp_compactor #(
  parameter int unsigned Y_WIDTH     = 501,
  parameter int unsigned SIG_WIDTH   = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] SEED        = 32'hFFFFFFFF,
  parameter int unsigned NUM_SAMPLES = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [Y_WIDTH-1:0]   y_i,
  input  logic                 y_valid_i,
  input  logic [SIG_WIDTH-1:0] exp_sig_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [SIG_WIDTH-1:0] signature_o,
  output logic [15:0]          sample_count_o
`ifdef YRESP_XCHECK_EN
  ,
  output logic                 x_seen_o
`endif
);

  localparam int unsigned NCHUNK = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int unsigned PADW   = NCHUNK * SIG_WIDTH;
  localparam logic [SIG_WIDTH-1:0] POLY_W   = SIG_WIDTH'(POLY);
  localparam logic [SIG_WIDTH-1:0] SEED_W   = SIG_WIDTH'(SEED);
  localparam logic [15:0]          LAST_CNT = 16'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 pass_q, pass_d;

  logic [PADW-1:0]      y_pad;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;
  logic                 accept;
  logic                 last;
  logic                 x_block;

  // Top chunk is zero-extended by padding the bus up to a whole chunk count.
  assign y_pad = PADW'(y_i);

  always_comb begin
    fold = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      fold = fold ^ y_pad[k*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY_W : '0)
                   ^ fold;

  // start wins over y_valid, so a sample on the start cycle is dropped.
  assign accept = (state_q == S_CAPTURE) && y_valid_i && !start_i;
  assign last   = accept && (cnt_q == LAST_CNT);

`ifdef YRESP_XCHECK_EN
  logic x_seen_q, x_seen_d;
  logic y_has_x;

  assign y_has_x = ((^y_i) === 1'bx);

  always_comb begin
    x_seen_d = x_seen_q;
    if (start_i) begin
      x_seen_d = 1'b0;
    end else if (accept) begin
      x_seen_d = x_seen_q | y_has_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_seen_q <= 1'b0;
    end else begin
      x_seen_q <= x_seen_d;
    end
  end

  assign x_seen_o = x_seen_q;
  assign x_block  = x_seen_d;
`else
  assign x_block  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    if (start_i) begin
      state_d = S_CAPTURE;
      sig_d   = SEED_W;
      cnt_d   = 16'd0;
      pass_d  = 1'b0;
    end else if (accept) begin
      sig_d = misr_next;
      cnt_d = cnt_q + 16'd1;
      if (last) begin
        state_d = S_DONE;
        pass_d  = (misr_next == exp_sig_i) && !x_block;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      cnt_q   <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy_o         = (state_q == S_CAPTURE);
  assign done_o         = (state_q == S_DONE);
  assign pass_o         = pass_q;
  assign signature_o    = sig_q;
  assign sample_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_y_resp_compactor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_y_resp_compactor
// Purpose : Scoreboard bench for y_resp_compactor over four configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_y_resp_compactor;

  typedef struct packed {
    logic [31:0] sig;
    logic [15:0] cnt;
    logic        done;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sa = 0, va = 0; logic [7:0] ya = 0, ea = 0;
  logic busy_a, done_a, pass_a; logic [7:0] sig_a; logic [15:0] cnt_a;
  logic sb = 0, vb = 0; logic [7:0] yb = 0, eb = 0;
  logic busy_b, done_b, pass_b; logic [7:0] sig_b; logic [15:0] cnt_b;
  logic sc = 0, vc = 0; logic [11:0] yc = 0; logic [7:0] ec = 0;
  logic busy_c, done_c, pass_c; logic [7:0] sig_c; logic [15:0] cnt_c;
  logic sd = 0, vd = 0; logic [500:0] yd = 0; logic [31:0] ed = 0;
  logic busy_d, done_d, pass_d; logic [31:0] sig_d; logic [15:0] cnt_d;
`ifdef YRESP_XCHECK_EN
  logic xs_a, xs_b, xs_c, xs_d;
`endif

  exp_t qa[$], qb[$], qc[$], qd[$];
  int n_vec = 0;
  int n_err = 0;

  y_resp_compactor #(.Y_WIDTH(8), .SIG_WIDTH(8), .POLY(32'h07), .SEED(32'h00), .NUM_SAMPLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(sa), .y_i(ya), .y_valid_i(va), .exp_sig_i(ea),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .signature_o(sig_a), .sample_count_o(cnt_a)
`ifdef YRESP_XCHECK_EN
    , .x_seen_o(xs_a)
`endif
  );
  y_resp_compactor #(.Y_WIDTH(8), .SIG_WIDTH(8), .POLY(32'h07), .SEED(32'hFF), .NUM_SAMPLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(sb), .y_i(yb), .y_valid_i(vb), .exp_sig_i(eb),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .signature_o(sig_b), .sample_count_o(cnt_b)
`ifdef YRESP_XCHECK_EN
    , .x_seen_o(xs_b)
`endif
  );
  y_resp_compactor #(.Y_WIDTH(12), .SIG_WIDTH(8), .SEED(32'h00), .NUM_SAMPLES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(sc), .y_i(yc), .y_valid_i(vc), .exp_sig_i(ec),
    .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .signature_o(sig_c), .sample_count_o(cnt_c)
`ifdef YRESP_XCHECK_EN
    , .x_seen_o(xs_c)
`endif
  );
  y_resp_compactor u_d (
    .clk(clk), .rst_n(rst_n), .start_i(sd), .y_i(yd), .y_valid_i(vd), .exp_sig_i(ed),
    .busy_o(busy_d), .done_o(done_d), .pass_o(pass_d), .signature_o(sig_d), .sample_count_o(cnt_d)
`ifdef YRESP_XCHECK_EN
    , .x_seen_o(xs_d)
`endif
  );

  function automatic exp_t mk(logic [31:0] s, logic [15:0] c, logic d, logic p);
    exp_t e;
    e.sig = s; e.cnt = c; e.done = d; e.pass = p;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic no_exp(string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s got=unexpected_output expected=none_queued", nm);
  endtask

  // Bit-serial fold plus MISR shift for the default 501/32 configuration.
  function automatic logic [31:0] ref_step(logic [31:0] s, logic [500:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 501; i++) f[i % 32] = f[i % 32] ^ y[i];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  always @(posedge clk) if (rst_n && va && busy_a && !sa) begin
    @(negedge clk);
    if (qa.size() == 0) no_exp("mon_a");
    else chk("mon_a", mk(32'(sig_a), cnt_a, done_a, pass_a), qa.pop_front());
  end
  always @(posedge clk) if (rst_n && vb && busy_b && !sb) begin
    @(negedge clk);
    if (qb.size() == 0) no_exp("mon_b");
    else chk("mon_b", mk(32'(sig_b), cnt_b, done_b, pass_b), qb.pop_front());
  end
  always @(posedge clk) if (rst_n && vc && busy_c && !sc) begin
    @(negedge clk);
    if (qc.size() == 0) no_exp("mon_c");
    else chk("mon_c", mk(32'(sig_c), cnt_c, done_c, pass_c), qc.pop_front());
  end
  always @(posedge clk) if (rst_n && vd && busy_d && !sd) begin
    @(negedge clk);
    if (qd.size() == 0) no_exp("mon_d");
    else chk("mon_d", mk(sig_d, cnt_d, done_d, pass_d), qd.pop_front());
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [500:0] yv [21];
  logic [31:0]  golden;

  task automatic run_d(int bad_k, logic exp_pass);
    logic [31:0]  s;
    logic [500:0] y;
    sd = 1; vd = 0;
    @(negedge clk);
    sd = 0;
    chk("d_start", {busy_d, done_d, pass_d, sig_d, cnt_d}, {3'b100, 32'hFFFFFFFF, 16'd0});
    s = 32'hFFFFFFFF;
    for (int k = 0; k < 21; k++) begin
      y = yv[k];
      if (k == bad_k) y[500] = ~y[500];
      s = ref_step(s, y);
      qd.push_back(mk(s, 16'(k + 1), k == 20, (k == 20) && exp_pass));
      vd = 1; yd = y;
      @(negedge clk);
      if (k % 5 == 4) begin
        vd = 0;
        @(negedge clk);
      end
    end
    vd = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [511:0] tmp;
    logic [31:0]  s;

    repeat (2) @(negedge clk);
    chk("rst_a", {busy_a, done_a, pass_a, sig_a, cnt_a}, 64'h0);
    chk("rst_d", {busy_d, done_d, pass_d, sig_d, cnt_d}, 64'h0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      va = i[0]; vb = ~i[0]; vc = i[0]; vd = i[0];
      ya = 8'hA5; yd = {501{1'b1}};
      @(negedge clk);
      chk("idle_a", {busy_a, done_a, pass_a, sig_a, cnt_a}, 64'h0);
      chk("idle_d", {busy_d, done_d, pass_d, sig_d, cnt_d}, 64'h0);
    end
    va = 0; vb = 0; vc = 0; vd = 0;

    // Basic MISR, then DONE must ignore further samples.
    sa = 1; @(negedge clk);
    sa = 0; va = 1; ya = 8'h01; ea = 8'h00; qa.push_back(mk(32'h01, 16'd1, 1'b0, 1'b0));
    @(negedge clk);
    ya = 8'h02; qa.push_back(mk(32'h00, 16'd2, 1'b1, 1'b1));
    @(negedge clk);
    ya = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_done_hold", {busy_a, done_a, pass_a, sig_a, cnt_a}, {3'b011, 8'h00, 16'd2});
    end

    // Restart with a sample on the start cycle, gaps, restart at count 1.
    sa = 1; va = 1; ya = 8'h77; @(negedge clk);
    sa = 0; ya = 8'h5A; qa.push_back(mk(32'h5A, 16'd1, 1'b0, 1'b0));
    @(negedge clk);
    va = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_gap_hold", {busy_a, done_a, pass_a, sig_a, cnt_a}, {3'b100, 8'h5A, 16'd1});
    end
    sa = 1; va = 1; ya = 8'h33; @(negedge clk);
    chk("a_restart", {busy_a, done_a, pass_a, sig_a, cnt_a}, {3'b100, 8'h00, 16'd0});
    sa = 0; ya = 8'h80; qa.push_back(mk(32'h80, 16'd1, 1'b0, 1'b0));
    @(negedge clk);
    va = 0;
    #2 rst_n = 0;
    #1 chk("a_async_rst", {busy_a, done_a, pass_a, sig_a, cnt_a}, 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Feedback tap.
    sb = 1; @(negedge clk);
    sb = 0; vb = 1; yb = 8'h00; eb = 8'h00; qb.push_back(mk(32'hF9, 16'd1, 1'b1, 1'b0));
    @(negedge clk);
    vb = 0;
    @(negedge clk);
    chk("b_done_hold", {busy_b, done_b, pass_b, sig_b, cnt_b}, {3'b010, 8'hF9, 16'd1});

    // Folding: 8'hBC ^ 8'h0A.
    sc = 1; @(negedge clk);
    sc = 0; vc = 1; yc = 12'hABC; ec = 8'hB6; qc.push_back(mk(32'hB6, 16'd1, 1'b1, 1'b1));
    @(negedge clk);
    vc = 0;
    @(negedge clk);

    // Default configuration, clean run then y[500] corrupted on one sample.
    for (int k = 0; k < 21; k++) begin
      tmp = '0;
      for (int i = 0; i < 16; i++) tmp[i*32 +: 32] = (32'h9E3779B9 * (k + 1)) ^ 32'(i);
      yv[k] = tmp[500:0];
    end
    s = 32'hFFFFFFFF;
    for (int k = 0; k < 21; k++) s = ref_step(s, yv[k]);
    golden = s;
    ed = golden;
    run_d(-1, 1'b1);
    chk("d_pass_hold", {busy_d, done_d, pass_d, cnt_d}, {3'b011, 16'd21});
    run_d(7, 1'b0);
    chk("d_fail_hold", {busy_d, done_d, pass_d, cnt_d}, {3'b010, 16'd21});

    repeat (3) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    chk("qc_drained", 64'(qc.size()), 64'd0);
    chk("qd_drained", 64'(qd.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
